// File: rtl/mc_controller.sv
// Multicycle control FSM for the 16-bit accumulator MIPS datapath.
// Decodes the IR and drives every datapath select/enable from the current state.
module mc_controller #(
  parameter int HALT_ON_ILLEGAL = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] instruction,
  input  logic        zero,
  output logic [1:0]  PCSrc,
  output logic        PCWrite,
  output logic        IorD,
  output logic        MemRead,
  output logic        MemWrite,
  output logic        Reg1Src,
  output logic        RegDst,
  output logic [1:0]  writeSrc,
  output logic        RegWrite,
  output logic        ALUSrcA,
  output logic [1:0]  ALUSrcB,
  output logic [2:0]  ALUop,
  output logic        IRWrite,
  output logic        halted
);

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEM_RD, S_LOAD_WB, S_STORE, S_JUMP, S_BRZ,
    S_MOVE, S_C_EXE, S_C_WB, S_I_EXE, S_I_WB, S_HALT
  } state_t;

  state_t      state_q, state_d;
  state_t      dec_next;
  logic [3:0]  opcode;
  logic [8:0]  func;
  logic [2:0]  c_alu_op;
  logic        reg1_alt;
  logic        unused_reg_field;

  assign opcode           = instruction[15:12];
  assign func             = instruction[8:0];
  assign unused_reg_field = ^instruction[11:9];

  // Instruction decode: DECODE successor and C-type ALU operation
  always_comb begin
    dec_next = (HALT_ON_ILLEGAL != 0) ? S_HALT : S_FETCH;
    c_alu_op = 3'b000;
    case (opcode)
      4'h0: dec_next = S_MEM_RD;
      4'h1: dec_next = S_STORE;
      4'h2: dec_next = S_JUMP;
      4'h4: dec_next = S_BRZ;
      4'hC, 4'hD, 4'hE, 4'hF: dec_next = S_I_EXE;
      4'h8: begin
        case (func)
          9'h001, 9'h002: dec_next = S_MOVE;
          9'h004: begin dec_next = S_C_EXE; c_alu_op = 3'b000; end
          9'h008: begin dec_next = S_C_EXE; c_alu_op = 3'b001; end
          9'h010: begin dec_next = S_C_EXE; c_alu_op = 3'b010; end
          9'h020: begin dec_next = S_C_EXE; c_alu_op = 3'b011; end
          9'h040: begin dec_next = S_C_EXE; c_alu_op = 3'b100; end
          9'h080: dec_next = S_FETCH;
          default: ;
        endcase
      end
      default: ;
    endcase
  end

  // MOVEFROM and NOT read Ri through port 1; A re-latches every cycle so the select is held
  assign reg1_alt = (opcode == 4'h8) && ((func == 9'h002) || (func == 9'h040));

  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: state_d = dec_next;
      S_MEM_RD: state_d = S_LOAD_WB;
      S_C_EXE:  state_d = S_C_WB;
      S_I_EXE:  state_d = S_I_WB;
      S_HALT:   state_d = S_HALT;
      default:  state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_FETCH;
    else     state_q <= state_d;
  end

  // Moore output decode; BRZ PCWrite is the only combinational path from zero
  always_comb begin
    PCSrc    = 2'd0;
    PCWrite  = 1'b0;
    IorD     = 1'b0;
    MemRead  = 1'b0;
    MemWrite = 1'b0;
    Reg1Src  = reg1_alt && (state_q != S_FETCH);
    RegDst   = 1'b0;
    writeSrc = 2'd0;
    RegWrite = 1'b0;
    ALUSrcA  = 1'b0;
    ALUSrcB  = 2'd0;
    ALUop    = 3'b000;
    IRWrite  = 1'b0;
    halted   = 1'b0;
    case (state_q)
      S_FETCH: begin
        MemRead = 1'b1;
        IRWrite = 1'b1;
        ALUSrcB = 2'd1;
        PCSrc   = 2'd3;
        PCWrite = 1'b1;
      end
      S_MEM_RD: begin
        IorD    = 1'b1;
        MemRead = 1'b1;
      end
      S_LOAD_WB: begin
        RegWrite = 1'b1;
        writeSrc = 2'd2;
      end
      S_STORE: begin
        IorD     = 1'b1;
        MemWrite = 1'b1;
      end
      S_JUMP: PCWrite = 1'b1;
      S_BRZ: begin
        ALUSrcA = 1'b1;
        ALUop   = 3'b101;
        PCWrite = zero;
      end
      S_MOVE: begin
        RegDst   = (func == 9'h001);
        RegWrite = 1'b1;
      end
      S_C_EXE: begin
        ALUSrcA = 1'b1;
        ALUop   = c_alu_op;
      end
      S_I_EXE: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'd2;
        ALUop   = {1'b0, opcode[1:0]};
      end
      S_C_WB, S_I_WB: begin
        RegWrite = 1'b1;
        writeSrc = 2'd1;
      end
      S_HALT: halted = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mc_controller.sv
// Directed bench for mc_controller: per-cycle expected control vectors are queued
// as each instruction is set up and compared as the FSM steps through it.
module tb_mc_controller;

  typedef struct packed {
    logic [1:0] pc_src;
    logic       pc_write;
    logic       ior_d;
    logic       mem_read;
    logic       mem_write;
    logic       reg1_src;
    logic       reg_dst;
    logic [1:0] write_src;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_op;
    logic       ir_write;
    logic       halted;
  } ctl_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] instruction;
  logic        zero;
  logic [1:0]  PCSrc, writeSrc, ALUSrcB;
  logic        PCWrite, IorD, MemRead, MemWrite, Reg1Src, RegDst, RegWrite;
  logic        ALUSrcA, IRWrite, halted;
  logic [2:0]  ALUop;
  ctl_t        obs;

  ctl_t  exp_q[$];
  string tag_q[$];
  int    tests = 0;
  int    fails = 0;

  mc_controller #(.HALT_ON_ILLEGAL(1)) dut (
    .clk(clk), .rst(rst), .instruction(instruction), .zero(zero),
    .PCSrc(PCSrc), .PCWrite(PCWrite), .IorD(IorD), .MemRead(MemRead),
    .MemWrite(MemWrite), .Reg1Src(Reg1Src), .RegDst(RegDst), .writeSrc(writeSrc),
    .RegWrite(RegWrite), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUop(ALUop),
    .IRWrite(IRWrite), .halted(halted)
  );

  always #5 clk = ~clk;

  assign obs = '{pc_src: PCSrc, pc_write: PCWrite, ior_d: IorD, mem_read: MemRead,
                 mem_write: MemWrite, reg1_src: Reg1Src, reg_dst: RegDst,
                 write_src: writeSrc, reg_write: RegWrite, alu_src_a: ALUSrcA,
                 alu_src_b: ALUSrcB, alu_op: ALUop, ir_write: IRWrite, halted: halted};

  function automatic ctl_t dflt();
    ctl_t c;
    c = '0;
    return c;
  endfunction

  function automatic ctl_t fetch_v();
    ctl_t c;
    c = '0;
    c.mem_read  = 1'b1;
    c.ir_write  = 1'b1;
    c.alu_src_b = 2'd1;
    c.pc_src    = 2'd3;
    c.pc_write  = 1'b1;
    return c;
  endfunction

  task automatic push(input ctl_t e, input string tag);
    exp_q.push_back(e);
    tag_q.push_back(tag);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_one();
    ctl_t  e;
    string t;
    tests++;
    assert (exp_q.size() != 0) else begin
      fails++;
      $error("FAIL scoreboard_empty observed=%h expected=queued_entry", obs);
    end
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      assert (obs === e) else begin
        fails++;
        $error("FAIL %s observed=%h expected=%h", t, obs, e);
      end
    end
  endtask

  task automatic run();
    while (exp_q.size() != 0) begin
      check_one();
      tick();
    end
  endtask

  // FETCH then DECODE; DECODE only shows Reg1Src for MOVEFROM/NOT
  task automatic push_fd(input logic r1, input string name);
    ctl_t d;
    d = dflt();
    d.reg1_src = r1;
    push(fetch_v(), {name, "_fetch"});
    push(d, {name, "_decode"});
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    ctl_t e;
    rst = 1'b1;
    instruction = 16'h0000;
    zero = 1'b0;
    repeat (2) tick();
    push(fetch_v(), "reset_fetch");
    check_one();
    rst = 1'b0;

    // LOAD 0x123
    instruction = 16'h0123;
    push_fd(1'b0, "load");
    e = dflt(); e.ior_d = 1'b1; e.mem_read = 1'b1; push(e, "load_memrd");
    e = dflt(); e.reg_write = 1'b1; e.write_src = 2'd2; push(e, "load_wb");
    run();

    // BRZ taken
    instruction = 16'h4050;
    zero = 1'b1;
    push_fd(1'b0, "brz1");
    e = dflt(); e.alu_src_a = 1'b1; e.alu_op = 3'b101; e.pc_write = 1'b1; push(e, "brz_taken");
    run();

    // BRZ not taken, then zero flipped inside the same cycle
    zero = 1'b0;
    push_fd(1'b0, "brz0");
    run();
    e = dflt(); e.alu_src_a = 1'b1; e.alu_op = 3'b101; push(e, "brz_not_taken");
    check_one();
    zero = 1'b1;
    #1;
    e.pc_write = 1'b1; push(e, "brz_zero_comb");
    check_one();
    zero = 1'b0;
    tick();

    // ADD R3
    instruction = 16'h8604;
    push_fd(1'b0, "add");
    e = dflt(); e.alu_src_a = 1'b1; e.alu_op = 3'b000; push(e, "add_exe");
    e = dflt(); e.reg_write = 1'b1; e.write_src = 2'd1; push(e, "add_wb");
    run();

    // MOVEFROM R3
    instruction = 16'h8602;
    push_fd(1'b1, "movefrom");
    e = dflt(); e.reg1_src = 1'b1; e.reg_write = 1'b1; push(e, "movefrom_wb");
    run();

    // MOVETO R3
    instruction = 16'h8601;
    push_fd(1'b0, "moveto");
    e = dflt(); e.reg_dst = 1'b1; e.reg_write = 1'b1; push(e, "moveto_wb");
    run();

    // NOT R5
    instruction = 16'h8A40;
    push_fd(1'b1, "not");
    e = dflt(); e.reg1_src = 1'b1; e.alu_src_a = 1'b1; e.alu_op = 3'b100; push(e, "not_exe");
    e = dflt(); e.reg1_src = 1'b1; e.reg_write = 1'b1; e.write_src = 2'd1; push(e, "not_wb");
    run();

    // OR R1
    instruction = 16'h8220;
    push_fd(1'b0, "or");
    e = dflt(); e.alu_src_a = 1'b1; e.alu_op = 3'b011; push(e, "or_exe");
    e = dflt(); e.reg_write = 1'b1; e.write_src = 2'd1; push(e, "or_wb");
    run();

    // NOP: two cycles
    instruction = 16'h8080;
    push_fd(1'b0, "nop");
    run();

    // SUBI -1
    instruction = 16'hD7FF;
    push_fd(1'b0, "subi");
    e = dflt(); e.alu_src_a = 1'b1; e.alu_src_b = 2'd2; e.alu_op = 3'b001; push(e, "subi_exe");
    e = dflt(); e.reg_write = 1'b1; e.write_src = 2'd1; push(e, "subi_wb");
    run();

    // ANDI
    instruction = 16'hE00F;
    push_fd(1'b0, "andi");
    e = dflt(); e.alu_src_a = 1'b1; e.alu_src_b = 2'd2; e.alu_op = 3'b010; push(e, "andi_exe");
    e = dflt(); e.reg_write = 1'b1; e.write_src = 2'd1; push(e, "andi_wb");
    run();

    // STORE
    instruction = 16'h1005;
    push_fd(1'b0, "store");
    e = dflt(); e.ior_d = 1'b1; e.mem_write = 1'b1; push(e, "store_wr");
    run();

    // JUMP
    instruction = 16'h2ABC;
    push_fd(1'b0, "jump");
    e = dflt(); e.pc_write = 1'b1; push(e, "jump_pc");
    run();

    // Reset during MEM_RD aborts the load
    instruction = 16'h0044;
    push_fd(1'b0, "rst_ld");
    run();
    e = dflt(); e.ior_d = 1'b1; e.mem_read = 1'b1; push(e, "rst_ld_memrd");
    check_one();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    push(fetch_v(), "rst_ld_after");
    check_one();
    tick();
    e = dflt(); push(e, "rst_ld_decode");
    check_one();
    tick();
    // IR still LOAD, so the FSM re-enters MEM_RD from a clean FETCH
    e = dflt(); e.ior_d = 1'b1; e.mem_read = 1'b1; push(e, "rst_ld_memrd2");
    check_one();
    tick();
    e = dflt(); e.reg_write = 1'b1; e.write_src = 2'd2; push(e, "rst_ld_wb2");
    check_one();
    tick();

    // Reset during C_WB: no writeback after the reset edge
    instruction = 16'h8608;
    push_fd(1'b0, "rst_sub");
    e = dflt(); e.alu_src_a = 1'b1; e.alu_op = 3'b001; push(e, "rst_sub_exe");
    run();
    e = dflt(); e.reg_write = 1'b1; e.write_src = 2'd1; push(e, "rst_sub_wb");
    check_one();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    push(fetch_v(), "rst_sub_after");
    check_one();
    instruction = 16'h8080;
    tick();
    push(dflt(), "rst_sub_nop_decode");
    check_one();
    tick();

    // Illegal opcode halts until reset
    instruction = 16'h3000;
    push_fd(1'b0, "ill_op");
    e = dflt(); e.halted = 1'b1;
    push(e, "halt_0"); push(e, "halt_1"); push(e, "halt_2");
    run();
    rst = 1'b1;
    tick();
    push(fetch_v(), "halt_rst_fetch");
    check_one();
    rst = 1'b0;

    // Two func bits set is illegal
    instruction = 16'h8003;
    push_fd(1'b0, "ill_func2");
    e = dflt(); e.halted = 1'b1; push(e, "ill_func2_halt");
    run();
    rst = 1'b1;
    tick();
    rst = 1'b0;

    // Func bit 8 is not a defined operation
    instruction = 16'h8100;
    push_fd(1'b0, "ill_func8");
    e = dflt(); e.halted = 1'b1; push(e, "ill_func8_halt");
    run();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    push(fetch_v(), "final_fetch");
    check_one();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
